execute_muldiv: RTL and testbench

Multi-cycle RV32M multiply/divide unit for the execute stage. It takes operands from decode when the opcode is OP and funct7 is 0000001, and computes MUL/MULH/MULHSU/MULHU on a fixed-latency pipelined path and DIV/DIVU/REM/REMU on an iterative path. It asserts a busy/stall toward decode while an operation is in flight, and delivers one registered result pulse toward memory access. It generalises the single-cycle ALU path with a parametrised datapath width and multiplier depth, a flush/kill input, and divide special-case handling.

---
 rtl/utils_top.sv | 24 ++
 rtl/execute_div_iter.sv | 59 +++++
 rtl/execute_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_top.sv
// utils_top: shared types and constants for the execute-stage M-extension unit.
package utils_top;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DFIX = 2'd3
  } md_state_t;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/execute_div_iter.sv
// execute_div_iter: restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done is high during the cycle whose closing edge shifts in the last quotient bit.
module execute_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN);

  logic            active;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   diff;

  // One extra bit on the partial remainder so the borrow of the trial subtract is visible.
  assign r_sh = {rem, quo[XLEN-1]};
  assign diff = r_sh - {1'b0, dvs};
  assign done = active & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else if (kill) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(XLEN-1);
      rem    <= '0;
      quo    <= dividend;
      dvs    <= divisor;
    end else if (active) begin
      if (diff[XLEN]) begin
        rem <= r_sh[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end else begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// execute_muldiv: RV32M multiply (pipelined) and divide (iterative) unit for the execute stage.
// Define EXECUTE_MULDIV_DIV_EN to build the divider; otherwise divide ops return all ones with ma_md_unsup.
module execute_muldiv
  import utils_top::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_md_valid,
  input  logic [2:0]      id_md_funct3,
  input  logic [XLEN-1:0] id_dat_a,
  input  logic [XLEN-1:0] id_dat_b,
  input  logic [4:0]      id_md_dst,
  input  logic            ex_flush,
  output logic            ex_md_ready,
  output logic            ex_md_busy,
  output logic            ma_md_valid,
  output logic [XLEN-1:0] ma_md_dat,
  output logic [4:0]      ma_md_dst,
  output logic            ma_md_unsup
);

  md_state_t       state, state_n;
  md_op_t          op;
  logic [1:0]      mul_cnt;
  logic            accept, is_mul, special, mul_done, dfix_done;
  logic [XLEN-1:0] spec_dat;
  logic            spec_unsup;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      dst_q;
  logic            mul_hi_q, mul_sa_q, mul_sb_q;
  logic            pend_vld, pend_unsup;
  logic [XLEN-1:0] pend_dat;
  logic [4:0]      pend_dst;
  logic [2*XLEN-1:0] a_w, b_w, prod;
  logic [XLEN-1:0] mul_sel, mul_tail;

  assign op          = md_op_t'(id_md_funct3);
  assign is_mul      = ~id_md_funct3[2];
  assign ex_md_ready = (state == ST_IDLE);
  assign ex_md_busy  = ~ex_md_ready;
  assign accept      = id_md_valid & ex_md_ready & ~ex_flush;

`ifdef EXECUTE_MULDIV_DIV_EN
  logic            div0, ovf, dsgn, a_neg, b_neg, div_start, div_done;
  logic [XLEN-1:0] a_mag, b_mag, div_q, div_r, q_fix, r_fix, dfix_res;
  logic            neg_q_q, neg_r_q, is_rem_q;

  assign div0       = (id_dat_b == '0);
  assign ovf        = ~id_md_funct3[0] & (id_dat_a == {1'b1, {(XLEN-1){1'b0}}}) & (id_dat_b == '1);
  assign special    = ~is_mul & (div0 | ovf);
  assign spec_dat   = id_md_funct3[1] ? (div0 ? id_dat_a : '0) : (div0 ? '1 : id_dat_a);
  assign spec_unsup = 1'b0;

  assign dsgn      = ~id_md_funct3[0];
  assign a_neg     = dsgn & id_dat_a[XLEN-1];
  assign b_neg     = dsgn & id_dat_b[XLEN-1];
  assign a_mag     = a_neg ? -id_dat_a : id_dat_a;
  assign b_mag     = b_neg ? -id_dat_b : id_dat_b;
  assign div_start = accept & ~is_mul & ~special;

  execute_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .kill     (ex_flush),
    .start    (div_start),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quo      (div_q),
    .rem      (div_r)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      is_rem_q <= id_md_funct3[1];
    end
  end

  assign q_fix    = neg_q_q ? -div_q : div_q;
  assign r_fix    = neg_r_q ? -div_r : div_r;
  assign dfix_res = is_rem_q ? r_fix : q_fix;
`else
  assign special    = ~is_mul;
  assign spec_dat   = '1;
  assign spec_unsup = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q      <= id_dat_a;
      b_q      <= id_dat_b;
      dst_q    <= id_md_dst;
      mul_hi_q <= (op != OP_MUL);
      mul_sa_q <= (op == OP_MULH) || (op == OP_MULHSU);
      mul_sb_q <= (op == OP_MULH);
    end
  end

  // Product modulo 2^(2*XLEN) of the extended operands gives both halves for every signedness.
  assign a_w     = {{XLEN{mul_sa_q & a_q[XLEN-1]}}, a_q};
  assign b_w     = {{XLEN{mul_sb_q & b_q[XLEN-1]}}, b_q};
  assign prod    = a_w * b_w;
  assign mul_sel = mul_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_tail = mul_sel;
    end else begin : g_mul_pipe
      logic [XLEN-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk) begin
        pipe[0] <= mul_sel;
        for (int i = 1; i < MUL_STAGES-1; i++) pipe[i] <= pipe[i-1];
      end
      assign mul_tail = pipe[MUL_STAGES-2];
    end
  endgenerate

  // state   | meaning
  // IDLE    | ready; divide special cases resolve here via the pending slot
  // MUL     | product travelling down the pipe, mul_cnt counts down
  // DIV     | divider shifting one quotient bit per cycle
  // DFIX    | sign correction of quotient/remainder
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept && is_mul)                       mul_cnt <= 2'(MUL_STAGES-1);
      else if (state_n == ST_IDLE)                mul_cnt <= '0;
      else if (state == ST_MUL && mul_cnt != '0)  mul_cnt <= mul_cnt - 2'd1;
    end
  end

  always_comb begin
    state_n   = state;
    mul_done  = 1'b0;
    dfix_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) state_n = ST_MUL;
`ifdef EXECUTE_MULDIV_DIV_EN
          else if (!special) state_n = ST_DIV;
`endif
        end
      end
      ST_MUL: begin
        if (mul_cnt == '0) begin
          state_n  = ST_IDLE;
          mul_done = 1'b1;
        end
      end
`ifdef EXECUTE_MULDIV_DIV_EN
      ST_DIV: begin
        if (div_done) state_n = ST_DFIX;
      end
      ST_DFIX: begin
        state_n   = ST_IDLE;
        dfix_done = 1'b1;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
    if (ex_flush && state != ST_IDLE) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ma_md_valid <= 1'b0;
      ma_md_dat   <= '0;
      ma_md_dst   <= '0;
      ma_md_unsup <= 1'b0;
      pend_vld    <= 1'b0;
      pend_dat    <= '0;
      pend_dst    <= '0;
      pend_unsup  <= 1'b0;
    end else begin
      ma_md_valid <= 1'b0;
      pend_vld    <= accept & special;
      if (accept && special) begin
        pend_dat   <= spec_dat;
        pend_dst   <= id_md_dst;
        pend_unsup <= spec_unsup;
      end
      if (!ex_flush) begin
        if (mul_done) begin
          ma_md_valid <= 1'b1;
          ma_md_dat   <= mul_tail;
          ma_md_dst   <= dst_q;
          ma_md_unsup <= 1'b0;
`ifdef EXECUTE_MULDIV_DIV_EN
        end else if (dfix_done) begin
          ma_md_valid <= 1'b1;
          ma_md_dat   <= dfix_res;
          ma_md_dst   <= dst_q;
          ma_md_unsup <= 1'b0;
`endif
        end else if (pend_vld) begin
          ma_md_valid <= 1'b1;
          ma_md_dat   <= pend_dat;
          ma_md_dst   <= pend_dst;
          ma_md_unsup <= pend_unsup;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: table-driven and scoreboard bench for execute_muldiv (XLEN=32, MUL_STAGES=2).
// Expectations follow EXECUTE_MULDIV_DIV_EN in the same way as the design.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_md_valid;
  logic [2:0]  id_md_funct3;
  logic [31:0] id_dat_a, id_dat_b;
  logic [4:0]  id_md_dst;
  logic        ex_flush;
  logic        ex_md_ready, ex_md_busy, ma_md_valid, ma_md_unsup;
  logic [31:0] ma_md_dat;
  logic [4:0]  ma_md_dst;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_md_valid  (id_md_valid),
    .id_md_funct3 (id_md_funct3),
    .id_dat_a     (id_dat_a),
    .id_dat_b     (id_dat_b),
    .id_md_dst    (id_md_dst),
    .ex_flush     (ex_flush),
    .ex_md_ready  (ex_md_ready),
    .ex_md_busy   (ex_md_busy),
    .ma_md_valid  (ma_md_valid),
    .ma_md_dat    (ma_md_dat),
    .ma_md_dst    (ma_md_dst),
    .ma_md_unsup  (ma_md_unsup)
  );

  typedef struct {
    logic [31:0] dat;
    logic [4:0]  dst;
    logic        unsup;
    int          lat;
    int          due;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic [31:0] dat;
    int          lat;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_drive = 0;
  exp_t sb[$];
  exp_t mon_e, ez, e;
  vec_t tv [19];
  int   first_drive, mul_drive;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, {31'b0, ex_md_ready}, 32'd1);
    chk({tag, "_busy"},  {31'b0, ex_md_busy},  32'd0);
    chk({tag, "_valid"}, {31'b0, ma_md_valid}, 32'd0);
    chk({tag, "_dat"},   ma_md_dat,            32'd0);
    chk({tag, "_dst"},   {27'b0, ma_md_dst},   32'd0);
    chk({tag, "_unsup"}, {31'b0, ma_md_unsup}, 32'd0);
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] dst);
    exp_t   r;
    longint pa, pb;
    logic [63:0] p;
`ifdef EXECUTE_MULDIV_DIV_EN
    logic [31:0] q, rm;
`endif
    r.dst = dst; r.unsup = 1'b0; r.lat = 2; r.due = 0; r.dat = '0;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r.dat = p[31:0]; end
      3'd1: begin pa = longint'($signed(a)); pb = longint'($signed(b)); p = pa * pb; r.dat = p[63:32]; end
      3'd2: begin pa = longint'($signed(a)); pb = longint'({32'b0, b}); p = pa * pb; r.dat = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r.dat = p[63:32]; end
      default: begin
`ifdef EXECUTE_MULDIV_DIV_EN
        r.lat = 33;
        if (b == 32'h0) begin
          q = 32'hFFFF_FFFF; rm = a; r.lat = 1;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = a; rm = 32'h0; r.lat = 1;
        end else if (!f3[0]) begin
          q = $signed(a) / $signed(b); rm = $signed(a) % $signed(b);
        end else begin
          q = a / b; rm = a % b;
        end
        r.dat = f3[1] ? rm : q;
`else
        r.dat = 32'hFFFF_FFFF; r.unsup = 1'b1; r.lat = 1;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input bit push, input exp_t x);
    int g = 0;
    exp_t y;
    while (ex_md_ready !== 1'b1 && g < 200) begin
      id_md_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("ready_timeout", 32'd0, 32'd1);
    id_md_valid  = 1'b1;
    id_md_funct3 = f3;
    id_dat_a     = a;
    id_dat_b     = b;
    id_md_dst    = dst;
    last_drive   = cyc;
    if (push) begin
      y = x;
      y.due = cyc + 1 + x.lat;
      sb.push_back(y);
    end
    @(negedge clk);
    id_md_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  task automatic kill_test(input bit use_rst);
`ifdef EXECUTE_MULDIV_DIV_EN
    issue(3'd4, 32'd100, 32'd7, 5'd20, 1'b0, ez);
    repeat (9) @(negedge clk);
`else
    issue(3'd0, 32'd5, 32'd6, 5'd20, 1'b0, ez);
`endif
    if (use_rst) rst = 1'b1;
    else         ex_flush = 1'b1;
    @(negedge clk);
    if (use_rst) check_reset("midop_rst");
    rst = 1'b0;
    ex_flush = 1'b0;
    chk(use_rst ? "kill_rst_ready" : "kill_flush_ready", {31'b0, ex_md_ready}, 32'd1);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 5'd21, 1'b1, model(3'd0, 32'd3, 32'd4, 5'd21));
    drain();
  endtask

  initial begin
    tv[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2};
    tv[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 2};
    tv[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 2};
    tv[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, 2};
    tv[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 33};
    tv[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 33};
    tv[6]  = '{3'd5, 32'd5,         32'd0,         5'd7,  32'hFFFF_FFFF, 1};
    tv[7]  = '{3'd7, 32'd5,         32'd0,         5'd8,  32'd5,         1};
    tv[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1};
    tv[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1};
    tv[10] = '{3'd0, 32'd3,         32'd4,         5'd11, 32'd12,        2};
    tv[11] = '{3'd5, 32'd100,       32'd7,         5'd12, 32'd14,        33};
    tv[12] = '{3'd7, 32'd100,       32'd7,         5'd13, 32'd2,         33};
    tv[13] = '{3'd4, 32'd10,        32'd2,         5'd14, 32'd5,         33};
    tv[14] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 2};
    tv[15] = '{3'd4, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1};
    tv[16] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFB, 1};
    tv[17] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd18, 32'd1,         33};
    tv[18] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         33};

    ez = '{32'd0, 5'd0, 1'b0, 0, 0};
    rst = 1'b1; ex_flush = 1'b0; id_md_valid = 1'b0;
    id_md_funct3 = 3'd0; id_dat_a = '0; id_dat_b = '0; id_md_dst = '0;

    fork
      forever begin
        @(negedge clk);
        if (ma_md_valid === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            chk("res_dat",   ma_md_dat,            mon_e.dat);
            chk("res_dst",   {27'b0, ma_md_dst},   {27'b0, mon_e.dst});
            chk("res_unsup", {31'b0, ma_md_unsup}, {31'b0, mon_e.unsup});
            chk("res_cycle", cyc,                  mon_e.due);
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Busy window of a single multiply
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd30, 1'b1, model(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd30));
    chk("mul_busy_c1", {31'b0, ex_md_busy}, 32'd1);
    @(negedge clk);
    chk("mul_busy_c2", {31'b0, ex_md_busy}, 32'd1);
    @(negedge clk);
    chk("mul_busy_done", {31'b0, ex_md_busy}, 32'd0);
    drain();

    for (int i = 0; i < 19; i++) begin
      e.dat = tv[i].dat; e.dst = tv[i].dst; e.unsup = 1'b0; e.lat = tv[i].lat; e.due = 0;
`ifndef EXECUTE_MULDIV_DIV_EN
      if (tv[i].f3[2]) begin
        e.dat = 32'hFFFF_FFFF; e.unsup = 1'b1; e.lat = 1;
      end
`endif
      issue(tv[i].f3, tv[i].a, tv[i].b, tv[i].dst, 1'b1, e);
    end
    drain();

    // Back-to-back: the second op goes in on the cycle the first result pulses
    issue(3'd0, 32'd9, 32'd9, 5'd22, 1'b1, model(3'd0, 32'd9, 32'd9, 5'd22));
    first_drive = last_drive;
    issue(3'd1, 32'hFFFF_FFF0, 32'd3, 5'd23, 1'b1, model(3'd1, 32'hFFFF_FFF0, 32'd3, 5'd23));
    chk("b2b_mul_accept", last_drive, first_drive + 3);
    drain();
`ifdef EXECUTE_MULDIV_DIV_EN
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd24, 1'b1, model(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd24));
    first_drive = last_drive;
    issue(3'd0, 32'd6, 32'd7, 5'd25, 1'b1, model(3'd0, 32'd6, 32'd7, 5'd25));
    mul_drive = last_drive;
    chk("b2b_div_accept", mul_drive, first_drive + 34);
    drain();
`endif

    for (int i = 0; i < 12; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      issue(f3, a, b, 5'(i), 1'b1, model(f3, a, b, 5'(i)));
    end
    drain();

    // Flush in the accept cycle blocks the accept
    id_md_valid = 1'b1; id_md_funct3 = 3'd0; id_dat_a = 32'd2; id_dat_b = 32'd2; ex_flush = 1'b1;
    @(negedge clk);
    id_md_valid = 1'b0; ex_flush = 1'b0;
    chk("flush_block_ready", {31'b0, ex_md_ready}, 32'd1);
    repeat (5) @(negedge clk);

    // Flush while a one-cycle result is being registered suppresses it
    issue(3'd5, 32'd5, 32'd0, 5'd26, 1'b0, ez);
    ex_flush = 1'b1;
    @(negedge clk);
    ex_flush = 1'b0;
    chk("flush_pend_ready", {31'b0, ex_md_ready}, 32'd1);
    repeat (5) @(negedge clk);

    kill_test(1'b0);
    kill_test(1'b1);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
